mem_fill_arbiter: RTL and testbench

//  Owns the single shared 4-cycle pipelined main memory and shares it between I-cache and D-cache.

---
 rtl/mem_fill_arbiter_if.sv | 39 +++
 rtl/mem_fill_arbiter.sv | 116 +++++++++++
 tb/tb_mem_fill_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_fill_arbiter_if.sv
// Cache-side and memory-side signal bundle of the fill arbiter.
// slave = arbiter view, master = cache/memory environment view.
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int WIDX_W = 3
);
  logic              i_miss;
  logic [ADDR_W-1:0] i_addr;
  logic              d_miss;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_wdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_valid;
  logic [15:0]       fill_data;
  logic [WIDX_W-1:0] fill_widx;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_done;
  logic              d_done;
  logic              d_wr_done;
  logic              busy;

  modport slave (
    input  i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    output mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_widx,
           i_fill_we, d_fill_we, i_done, d_done, d_wr_done, busy
  );

  modport master (
    output i_miss, i_addr, d_miss, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
    input  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_widx,
           i_fill_we, d_fill_we, i_done, d_done, d_wr_done, busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined main memory between I-cache and D-cache: fixed-priority
// grant, block-fill read issue, and steering of returned words to the owner.
module mem_fill_arbiter #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8,
  parameter int WIDX_W = 3
)(
  input logic              clk,
  input logic              rst_n,
  mem_fill_arbiter_if.slave bus
);
  localparam logic [WIDX_W:0] NW  = (WIDX_W+1)'(WORDS);
  localparam logic [WIDX_W:0] ONE = (WIDX_W+1)'(1);

  typedef enum logic [2:0] {IDLE, D_WRITE, D_FILL, I_FILL, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [WIDX_W:0]   issue_q, issue_d;
  logic [WIDX_W:0]   recv_q, recv_d;
  logic              dfill_q, dfill_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      issue_q <= '0;
      recv_q  <= '0;
      dfill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      dfill_q <= dfill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    dfill_d = dfill_q;
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.fill_data = '0;
    bus.fill_widx = '0;
    bus.i_fill_we = 1'b0;
    bus.d_fill_we = 1'b0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.d_wr_done = 1'b0;
    bus.busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        issue_d = '0;
        recv_d  = '0;
        if (bus.d_wr) begin
          state_d = D_WRITE;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
        end else if (bus.d_miss) begin
          state_d = D_FILL;
          addr_d  = bus.d_addr;
          dfill_d = 1'b1;
        end else if (bus.i_miss) begin
          state_d = I_FILL;
          addr_d  = bus.i_addr;
          dfill_d = 1'b0;
        end
      end

      D_WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.d_wr_done = 1'b1;
        state_d       = IDLE;
      end

      D_FILL, I_FILL: begin
        // issue and receive run concurrently; reads go out back to back
        if (issue_q < NW) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = {addr_q[ADDR_W-1:WIDX_W+1], issue_q[WIDX_W-1:0], 1'b0};
          issue_d      = issue_q + ONE;
        end
        if (bus.mem_valid) begin
          bus.fill_data = bus.mem_rdata;
          bus.fill_widx = recv_q[WIDX_W-1:0];
          bus.d_fill_we = (state_q == D_FILL);
          bus.i_fill_we = (state_q == I_FILL);
          recv_d        = recv_q + ONE;
          if (recv_q == NW - ONE) state_d = DONE;
        end
      end

      DONE: begin
        bus.d_done = dfill_q;
        bus.i_done = !dfill_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: cycle-indexed expected-output schedule built from
// the transaction timing rules, plus a 4-cycle-latency memory model.
module tb_mem_fill_arbiter;
  localparam int MEM_LAT = 4;

  typedef struct packed {
    logic        en, wr;
    logic [15:0] addr, wdata;
    logic        iwe, dwe;
    logic [2:0]  widx;
    logic [15:0] fdata;
    logic        idone, ddone, wrdone, busy;
  } exp_t;

  logic clk, rst_n;
  int   cyc, tests, fails, nstrobe;
  exp_t sched[int];
  logic [15:0] rd_pipe[int];
  logic spur;
  logic [15:0] spur_data;

  mem_fill_arbiter_if #(.ADDR_W(16), .WIDX_W(3)) bus ();
  mem_fill_arbiter #(.ADDR_W(16), .WORDS(8), .WIDX_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #200000; $error("FAIL watchdog expired"); $fatal(1, "timeout"); end

  function automatic logic [15:0] memword(logic [15:0] a);
    return (a ^ 16'h5A3C) + {a[7:0], a[15:8]};
  endfunction

  function automatic exp_t get(int c);
    if (sched.exists(c)) return sched[c];
    return '0;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Memory: a read seen in cycle t returns its word in cycle t+MEM_LAT
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    bus.mem_valid = rd_pipe.exists(cyc) || spur;
    bus.mem_rdata = rd_pipe.exists(cyc) ? rd_pipe[cyc] : (spur ? spur_data : 16'h0);
  end

  always @(negedge clk) begin
    exp_t e;
    e = get(cyc);
    if (bus.mem_en && !bus.mem_wr) rd_pipe[cyc + MEM_LAT] = memword(bus.mem_addr);
    chk("mem_en",    bus.mem_en,    e.en);
    chk("mem_wr",    bus.mem_wr,    e.wr);
    chk("mem_addr",  bus.mem_addr,  e.addr);
    chk("mem_wdata", bus.mem_wdata, e.wdata);
    chk("i_fill_we", bus.i_fill_we, e.iwe);
    chk("d_fill_we", bus.d_fill_we, e.dwe);
    chk("fill_widx", bus.fill_widx, e.widx);
    chk("fill_data", bus.fill_data, e.fdata);
    chk("i_done",    bus.i_done,    e.idone);
    chk("d_done",    bus.d_done,    e.ddone);
    chk("d_wr_done", bus.d_wr_done, e.wrdone);
    chk("busy",      bus.busy,      e.busy);
    chk("we_excl",   bus.i_fill_we && bus.d_fill_we, 0);
    if (!bus.busy) chk("idle_mem_en", bus.mem_en, 0);
    if (!rst_n) nstrobe = 0;
    else begin
      if (bus.i_fill_we || bus.d_fill_we) nstrobe++;
      if (bus.i_done || bus.d_done) begin
        chk("strobes_per_fill", nstrobe, 8);
        chk("done_mem_en", bus.mem_en, 0);
        nstrobe = 0;
      end
    end
  end

  task automatic plan_fill(int g, logic [11:0] blk, bit isd);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] w;
      w = 3'(k);
      e = get(g + 1 + k); e.en = 1; e.addr = {blk, w, 1'b0}; sched[g + 1 + k] = e;
      e = get(g + 5 + k); e.widx = w; e.fdata = memword({blk, w, 1'b0});
      if (isd) e.dwe = 1; else e.iwe = 1;
      sched[g + 5 + k] = e;
    end
    for (int k = 1; k <= 13; k++) begin e = get(g + k); e.busy = 1; sched[g + k] = e; end
    e = get(g + 13);
    if (isd) e.ddone = 1; else e.idone = 1;
    sched[g + 13] = e;
  endtask

  task automatic plan_store(int g, logic [15:0] a, logic [15:0] d);
    exp_t e;
    e = get(g + 1);
    e.en = 1; e.wr = 1; e.addr = a; e.wdata = d; e.wrdone = 1; e.busy = 1;
    sched[g + 1] = e;
  endtask

  task automatic wait_cyc(int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 1000) begin @(posedge clk); #1; guard++; end
    chk("wait_bound", cyc, n);
  endtask

  // Raise the given requests together in the current IDLE cycle; the model
  // serves them in priority order and each is dropped on its completion cycle.
  task automatic do_req(bit wr, bit dm, bit im, logic [15:0] ia, logic [15:0] da, logic [15:0] dd);
    int c;
    c = cyc;
    bus.i_miss = im; bus.i_addr = ia;
    bus.d_miss = dm; bus.d_wr = wr; bus.d_addr = da; bus.d_wdata = dd;
    if (wr) begin plan_store(c, da, dd); wait_cyc(c + 1); bus.d_wr = 0; c = c + 2; end
    if (dm) begin plan_fill(c, da[15:4], 1); wait_cyc(c + 13); bus.d_miss = 0; c = c + 14; end
    if (im) begin plan_fill(c, ia[15:4], 0); wait_cyc(c + 13); bus.i_miss = 0; c = c + 14; end
    wait_cyc(c);
  endtask

  initial begin
    int c, r;
    cyc = 0; tests = 0; fails = 0; nstrobe = 0; spur = 0; spur_data = 0;
    rst_n = 0;
    bus.i_miss = 0; bus.i_addr = 0; bus.d_miss = 0; bus.d_wr = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_valid = 0; bus.mem_rdata = 0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_fill_data", bus.fill_data, 0);
    @(posedge clk); #1;
    rst_n = 1;
    wait_cyc(cyc + 2);

    do_req(0, 0, 1, 16'h0046, 16'h0, 16'h0);          // I fill
    do_req(0, 1, 1, 16'h0000, 16'h2010, 16'h0);       // D beats I
    do_req(1, 0, 0, 16'h0, 16'h1234, 16'hBEEF);       // single store
    do_req(1, 1, 0, 16'h0, 16'h5678, 16'h1357);       // store then fill

    // Hold: request dropped and address changed mid-fill
    c = cyc;
    bus.i_miss = 1; bus.i_addr = 16'h0046;
    plan_fill(c, 12'h004, 0);
    wait_cyc(c + 3);
    bus.i_miss = 0; bus.i_addr = 16'hFFF0;
    wait_cyc(c + 14);

    // Reset at the 5th returned word
    c = cyc;
    bus.i_miss = 1; bus.i_addr = 16'h3A5C;
    plan_fill(c, 12'h3A5, 0);
    wait_cyc(c + 9);
    chk("pre_rst_we", bus.i_fill_we, 1);
    chk("pre_rst_widx", bus.fill_widx, 4);
    #1;
    rst_n = 0; bus.i_miss = 0;
    for (int k = c + 9; k <= c + 14; k++) if (sched.exists(k)) sched.delete(k);
    #1;
    chk("async_rst_we", bus.i_fill_we, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_data", bus.fill_data, 0);
    chk("async_rst_widx", bus.fill_widx, 0);
    wait_cyc(c + 11);
    rst_n = 1;
    wait_cyc(c + 13);                                  // stale reads drain in IDLE
    do_req(0, 0, 1, 16'h3A50, 16'h0, 16'h0);

    // Spurious mem_valid while idle
    spur = 1; spur_data = 16'hDEAD;
    wait_cyc(cyc + 3);
    chk("spur_we", bus.i_fill_we | bus.d_fill_we, 0);
    chk("spur_busy", bus.busy, 0);
    spur = 0;
    wait_cyc(cyc + 1);

    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(1, 7);
      do_req(r[0], r[1], r[2], 16'($urandom), 16'($urandom), 16'($urandom));
      wait_cyc(cyc + $urandom_range(0, 2));
    end
    wait_cyc(cyc + 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
